// File: rtl/audio_bus_responder.sv
// Bus-side front end of the audio core: a ctrl/fifospace/left/right register window over an
// ADC receive frame FIFO (drained by bus reads) and a DAC transmit frame FIFO (filled by bus writes).
module audio_bus_responder #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_3040,
  parameter int          DEPTH_LOG2 = 2,
  parameter int          SAMPLE_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         bus_addr,
  input  logic [3:0]          bus_byte_enable,
  input  logic                bus_read,
  input  logic                bus_write,
  input  logic [31:0]         bus_write_data,
  output logic                bus_ack,
  output logic [31:0]         bus_read_data,
  input  logic                adc_valid,
  input  logic [SAMPLE_W-1:0] adc_left,
  input  logic [SAMPLE_W-1:0] adc_right,
  output logic                dac_valid,
  input  logic                dac_ready,
  output logic [SAMPLE_W-1:0] dac_left,
  output logic [SAMPLE_W-1:0] dac_right
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef enum logic [1:0] {IDLE, ACK, RELEASE} state_t;

  state_t                state;
  logic [SAMPLE_W-1:0]   left_hold;
  logic                  overrun, overflow, underflow;

  logic [SAMPLE_W-1:0]   rx_mem_l [DEPTH];
  logic [SAMPLE_W-1:0]   rx_mem_r [DEPTH];
  logic [SAMPLE_W-1:0]   tx_mem_l [DEPTH];
  logic [SAMPLE_W-1:0]   tx_mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wr, rx_rd, tx_wr, tx_rd;
  logic [CW-1:0]         rx_count, tx_count;

  logic unused_byte_enable;
  assign unused_byte_enable = ^bus_byte_enable;

  // A request is decoded only on the IDLE edge, so each side effect fires exactly once.
  logic accept, rd_acc, wr_acc;
  logic hit_ctrl, hit_space, hit_left, hit_right;
  assign accept    = (state == IDLE) && (bus_read || bus_write);
  assign rd_acc    = accept && bus_read;
  assign wr_acc    = accept && bus_write && !bus_read;
  assign hit_ctrl  = (bus_addr == BASE_ADDR);
  assign hit_space = (bus_addr == BASE_ADDR + 32'd4);
  assign hit_left  = (bus_addr == BASE_ADDR + 32'd8);
  assign hit_right = (bus_addr == BASE_ADDR + 32'd12);

  logic rx_empty, rx_full, tx_full;
  logic rx_pop, rx_push_ok, rx_clear, underflow_set;
  logic tx_pop, tx_push_req, tx_push_ok, tx_clear, sticky_clear;
  assign rx_empty      = (rx_count == '0);
  assign rx_full       = (rx_count == CW'(DEPTH));
  assign tx_full       = (tx_count == CW'(DEPTH));
  assign rx_pop        = rd_acc && hit_right && !rx_empty;
  assign underflow_set = rd_acc && hit_right && rx_empty;
  assign rx_clear      = wr_acc && hit_ctrl && bus_write_data[0];
  assign tx_clear      = wr_acc && hit_ctrl && bus_write_data[1];
  assign sticky_clear  = wr_acc && hit_ctrl && bus_write_data[2];
  assign rx_push_ok    = adc_valid && (!rx_full || rx_pop);
  assign dac_valid     = (tx_count != '0);
  assign tx_pop        = dac_valid && dac_ready;
  assign tx_push_req   = wr_acc && hit_right;
  assign tx_push_ok    = tx_push_req && (!tx_full || tx_pop);

  assign dac_left  = dac_valid ? tx_mem_l[tx_rd] : '0;
  assign dac_right = dac_valid ? tx_mem_r[tx_rd] : '0;

  function automatic logic [7:0] sat8(input logic [CW-1:0] v);
    logic [31:0] w;
    w = 32'(v);
    return (w > 32'd255) ? 8'hFF : w[7:0];
  endfunction

  logic [7:0]  rx_avail8, tx_space8;
  logic [31:0] read_value;
  assign rx_avail8 = sat8(rx_count);
  assign tx_space8 = sat8(CW'(DEPTH) - tx_count);

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    read_value = '0;
    if (hit_ctrl)
      read_value = {21'b0, overrun, overflow, underflow, 8'b0};
    else if (hit_space)
      read_value = {tx_space8, tx_space8, rx_avail8, rx_avail8};
    else if (hit_left && !rx_empty)
      read_value = 32'(rx_mem_l[rx_rd]);
    else if (hit_right && !rx_empty)
      read_value = 32'(rx_mem_r[rx_rd]);
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      bus_ack       <= 1'b0;
      bus_read_data <= '0;
      left_hold     <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state   <= ACK;
          bus_ack <= 1'b1;
          if (bus_read) bus_read_data <= read_value;
          if (wr_acc && hit_left) left_hold <= bus_write_data[SAMPLE_W-1:0];
        end
        ACK: begin
          state   <= RELEASE;
          bus_ack <= 1'b0;
        end
        RELEASE: if (!bus_read && !bus_write) state <= IDLE;
        default: begin
          state   <= IDLE;
          bus_ack <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (sticky_clear) begin
      overrun   <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (adc_valid && !rx_push_ok && !rx_clear) overrun <= 1'b1;
      if (tx_push_req && !tx_push_ok)            overflow <= 1'b1;
      if (underflow_set)                         underflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_count <= '0;
    end else if (rx_clear) begin
      rx_wr    <= '0;
      rx_rd    <= '0;
      rx_count <= '0;
    end else begin
      if (rx_push_ok) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)     rx_rd <= rx_rd + 1'b1;
      rx_count <= rx_count + CW'(rx_push_ok) - CW'(rx_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
    end else if (tx_clear) begin
      tx_wr    <= '0;
      tx_rd    <= '0;
      tx_count <= '0;
    end else begin
      if (tx_push_ok) tx_wr <= tx_wr + 1'b1;
      if (tx_pop)     tx_rd <= tx_rd + 1'b1;
      tx_count <= tx_count + CW'(tx_push_ok) - CW'(tx_pop);
    end
  end

  // NOTE: frame storage has no reset; the counts gate every read so stale contents never escape.
  always_ff @(posedge clk) begin
    if (rx_push_ok && !rx_clear) begin
      rx_mem_l[rx_wr] <= adc_left;
      rx_mem_r[rx_wr] <= adc_right;
    end
    if (tx_push_ok && !tx_clear) begin
      tx_mem_l[tx_wr] <= left_hold;
      tx_mem_r[tx_wr] <= bus_write_data[SAMPLE_W-1:0];
    end
  end

endmodule

// File: tb/tb_audio_bus_responder.sv
// Self-checking bench for audio_bus_responder: directed vector table, hand sequences for
// multi-cycle corners, and random bus/ADC traffic against a queue-based register-window model.
module tb_audio_bus_responder;

  localparam logic [31:0] BASE = 32'h0000_3040;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bus_addr, bus_write_data, bus_read_data;
  logic [3:0]  bus_byte_enable;
  logic        bus_read, bus_write, bus_ack;
  logic        adc_valid, dac_valid, dac_ready;
  logic [31:0] adc_left, adc_right, dac_left, dac_right;

  audio_bus_responder #(.BASE_ADDR(BASE), .DEPTH_LOG2(2), .SAMPLE_W(32)) dut (
    .clk(clk), .rst(rst),
    .bus_addr(bus_addr), .bus_byte_enable(bus_byte_enable),
    .bus_read(bus_read), .bus_write(bus_write), .bus_write_data(bus_write_data),
    .bus_ack(bus_ack), .bus_read_data(bus_read_data),
    .adc_valid(adc_valid), .adc_left(adc_left), .adc_right(adc_right),
    .dac_valid(dac_valid), .dac_ready(dac_ready),
    .dac_left(dac_left), .dac_right(dac_right)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: the register window described as two frame queues plus sticky flags.
  typedef struct { logic [31:0] l; logic [31:0] r; } frame_t;
  frame_t      m_rx[$];
  frame_t      m_tx[$];
  logic        m_ovr, m_ovf, m_und;
  logic [31:0] m_hold;

  task automatic model_reset();
    m_rx.delete(); m_tx.delete();
    m_ovr = 0; m_ovf = 0; m_und = 0; m_hold = 0;
  endtask

  task automatic model_read(input logic [31:0] addr, output logic [31:0] exp);
    int sp, av;
    exp = 0;
    if (addr == BASE) begin
      exp = (32'(m_ovr) << 10) | (32'(m_ovf) << 9) | (32'(m_und) << 8);
    end else if (addr == BASE + 4) begin
      sp = DEPTH - m_tx.size(); av = m_rx.size();
      exp = (sp << 24) | (sp << 16) | (av << 8) | av;
    end else if (addr == BASE + 8) begin
      if (m_rx.size() > 0) exp = m_rx[0].l;
    end else if (addr == BASE + 12) begin
      if (m_rx.size() > 0) begin
        exp = m_rx[0].r;
        void'(m_rx.pop_front());
      end else m_und = 1;
    end
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] d);
    frame_t f;
    if (addr == BASE) begin
      if (d[0]) m_rx.delete();
      if (d[1]) m_tx.delete();
      if (d[2]) begin m_ovr = 0; m_ovf = 0; m_und = 0; end
    end else if (addr == BASE + 8) begin
      m_hold = d;
    end else if (addr == BASE + 12) begin
      if (m_tx.size() < DEPTH) begin f.l = m_hold; f.r = d; m_tx.push_back(f); end
      else m_ovf = 1;
    end
  endtask

  task automatic model_adc(input logic [31:0] l, input logic [31:0] r);
    frame_t f;
    f.l = l; f.r = r;
    if (m_rx.size() < DEPTH) m_rx.push_back(f);
    else m_ovr = 1;
  endtask

  // All tasks start and end just after a falling edge.
  task automatic bus_access(input logic [31:0] addr, input logic rd, input logic wr,
                            input logic [31:0] wdata, input int hold, input logic adc_with,
                            input logic [31:0] al, input logic [31:0] ar,
                            output logic [31:0] data, output int acks);
    logic got;
    got = 0; acks = 0; data = 'x;
    bus_addr = addr; bus_read = rd; bus_write = wr; bus_write_data = wdata;
    if (adc_with) begin adc_valid = 1; adc_left = al; adc_right = ar; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      adc_valid = 0;
      if (bus_ack) begin got = 1; acks++; data = bus_read_data; end
    end
    if (!got) check($sformatf("ack_timeout_%h", addr), 32'(got), 32'd1);
    repeat (hold) begin @(negedge clk); if (bus_ack) acks++; end
    bus_read = 0; bus_write = 0;
    repeat (2) begin @(negedge clk); if (bus_ack) acks++; end
  endtask

  task automatic bus_rd(input logic [31:0] addr, output logic [31:0] data);
    int acks;
    bus_access(addr, 1, 0, 0, 0, 0, 0, 0, data, acks);
    check($sformatf("ack_count_rd_%h", addr), acks, 1);
  endtask

  task automatic bus_wr(input logic [31:0] addr, input logic [31:0] d);
    logic [31:0] unused_data;
    int acks;
    bus_access(addr, 0, 1, d, 0, 0, 0, 0, unused_data, acks);
    check($sformatf("ack_count_wr_%h", addr), acks, 1);
  endtask

  task automatic adc_push(input logic [31:0] l, input logic [31:0] r);
    adc_valid = 1; adc_left = l; adc_right = r;
    @(negedge clk);
    adc_valid = 0;
  endtask

  typedef enum {OP_RD, OP_WR, OP_ADC} op_e;
  typedef struct { op_e op; logic [31:0] addr; logic [31:0] d0; logic [31:0] d1; logic [31:0] exp; } vec_t;
  vec_t tbl[18];

  logic [31:0] rdata, exp;
  int          acks;

  initial begin
    tbl[0]  = '{OP_RD,  BASE + 4,  0, 0, 32'h0404_0000};
    tbl[1]  = '{OP_RD,  BASE,      0, 0, 32'h0000_0000};
    tbl[2]  = '{OP_ADC, 0,         1, 2, 0};
    tbl[3]  = '{OP_ADC, 0,         3, 4, 0};
    tbl[4]  = '{OP_RD,  BASE + 4,  0, 0, 32'h0404_0202};
    tbl[5]  = '{OP_RD,  BASE + 8,  0, 0, 32'd1};
    tbl[6]  = '{OP_RD,  BASE + 12, 0, 0, 32'd2};
    tbl[7]  = '{OP_RD,  BASE + 4,  0, 0, 32'h0404_0101};
    tbl[8]  = '{OP_RD,  BASE + 8,  0, 0, 32'd3};
    tbl[9]  = '{OP_RD,  BASE + 12, 0, 0, 32'd4};
    tbl[10] = '{OP_RD,  BASE + 4,  0, 0, 32'h0404_0000};
    tbl[11] = '{OP_RD,  BASE + 12, 0, 0, 32'd0};
    tbl[12] = '{OP_RD,  BASE,      0, 0, 32'h0000_0100};
    tbl[13] = '{OP_WR,  BASE,      4, 0, 0};
    tbl[14] = '{OP_RD,  BASE,      0, 0, 32'h0000_0000};
    tbl[15] = '{OP_RD,  32'h3050,  0, 0, 32'h0000_0000};
    tbl[16] = '{OP_WR,  BASE + 4,  32'hFFFF_FFFF, 0, 0};
    tbl[17] = '{OP_RD,  BASE + 4,  0, 0, 32'h0404_0000};

    rst = 0; bus_addr = 0; bus_byte_enable = 4'hF; bus_read = 0; bus_write = 0;
    bus_write_data = 0; adc_valid = 0; adc_left = 0; adc_right = 0; dac_ready = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_ack", 32'(bus_ack), 0);
    check("reset_rdata", bus_read_data, 0);
    check("reset_dac_valid", 32'(dac_valid), 0);
    check("reset_dac_data", dac_left | dac_right, 0);
    rst = 1;
    @(negedge clk);

    // Directed vectors.
    for (int i = 0; i < 18; i++) begin
      case (tbl[i].op)
        OP_ADC: begin adc_push(tbl[i].d0, tbl[i].d1); model_adc(tbl[i].d0, tbl[i].d1); end
        OP_WR:  begin bus_wr(tbl[i].addr, tbl[i].d0); model_write(tbl[i].addr, tbl[i].d0); end
        default: begin
          bus_rd(tbl[i].addr, rdata);
          model_read(tbl[i].addr, exp);
          check($sformatf("vec%0d_rd_%h", i, tbl[i].addr), rdata, tbl[i].exp);
        end
      endcase
    end

    // Request held for 5 cycles yields a single ack.
    bus_access(BASE + 4, 1, 0, 0, 5, 0, 0, 0, rdata, acks);
    check("held_read_acks", acks, 1);
    check("held_read_data", rdata, 32'h0404_0000);

    // TX overflow with the DAC stalled, then drain in order.
    for (int i = 0; i < 5; i++) begin
      bus_wr(BASE + 8, 32'hA0 + i);  model_write(BASE + 8, 32'hA0 + i);
      bus_wr(BASE + 12, 32'hB0 + i); model_write(BASE + 12, 32'hB0 + i);
    end
    bus_rd(BASE + 4, rdata); model_read(BASE + 4, exp);
    check("tx_full_space", rdata, 32'h0000_0000);
    bus_rd(BASE, rdata); model_read(BASE, exp);
    check("tx_overflow_flag", rdata, 32'h0000_0200);
    dac_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_valid", i), 32'(dac_valid), 1);
      check($sformatf("drain%0d_left", i), dac_left, 32'hA0 + i);
      check($sformatf("drain%0d_right", i), dac_right, 32'hB0 + i);
      @(negedge clk);
    end
    check("drain_done_valid", 32'(dac_valid), 0);
    dac_ready = 0;
    m_tx.delete();
    bus_wr(BASE, 4); model_write(BASE, 4);

    // RX overrun, then a push coincident with a pop at full.
    for (int i = 0; i < 5; i++) begin
      adc_push(10 + i, 20 + i); model_adc(10 + i, 20 + i);
    end
    bus_rd(BASE, rdata); model_read(BASE, exp);
    check("rx_overrun_flag", rdata, 32'h0000_0400);
    bus_access(BASE + 12, 1, 0, 0, 0, 1, 99, 98, rdata, acks);
    model_read(BASE + 12, exp); model_adc(99, 98);
    check("push_pop_data", rdata, 32'd20);
    bus_rd(BASE + 4, rdata); model_read(BASE + 4, exp);
    check("push_pop_count", rdata, 32'h0404_0404);

    // Read and write together: read wins, no TX push.
    bus_access(BASE + 12, 1, 1, 32'h55, 0, 0, 0, 0, rdata, acks);
    model_read(BASE + 12, exp);
    check("rdwr_data", rdata, 32'd21);
    bus_rd(BASE + 4, rdata); model_read(BASE + 4, exp);
    check("rdwr_space", rdata, 32'h0404_0303);
    check("rdwr_no_dac", 32'(dac_valid), 0);
    bus_wr(BASE, 7); model_write(BASE, 7);

    // Random traffic against the model.
    for (int n = 0; n < 250; n++) begin
      int sel;
      logic [31:0] a, d;
      sel = $urandom_range(0, 9);
      d = $urandom;
      case (sel)
        0, 1: begin adc_push(d, ~d); model_adc(d, ~d); end
        2: begin a = BASE + 32'(4 * $urandom_range(0, 3)); bus_rd(a, rdata); model_read(a, exp);
                 check($sformatf("rand%0d_rd_%h", n, a), rdata, exp); end
        3, 4: begin bus_rd(BASE + 12, rdata); model_read(BASE + 12, exp);
                    check($sformatf("rand%0d_pop", n), rdata, exp); end
        5: begin bus_rd(BASE + 8, rdata); model_read(BASE + 8, exp);
                 check($sformatf("rand%0d_left", n), rdata, exp); end
        6: begin bus_wr(BASE + 8, d); model_write(BASE + 8, d); end
        7: begin bus_wr(BASE + 12, d); model_write(BASE + 12, d); end
        8: begin d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) : 32'd4;
                 bus_wr(BASE, d); model_write(BASE, d); end
        default: begin bus_rd(32'h3050, rdata); model_read(32'h3050, exp);
                       check($sformatf("rand%0d_unmapped", n), rdata, exp); end
      endcase
    end
    bus_rd(BASE + 4, rdata); model_read(BASE + 4, exp);
    check("rand_final_space", rdata, exp);
    bus_rd(BASE, rdata); model_read(BASE, exp);
    check("rand_final_ctrl", rdata, exp);
    dac_ready = 1;
    while (m_tx.size() > 0) begin
      check("rand_drain_valid", 32'(dac_valid), 1);
      check("rand_drain_left", dac_left, m_tx[0].l);
      check("rand_drain_right", dac_right, m_tx[0].r);
      void'(m_tx.pop_front());
      @(negedge clk);
    end
    check("rand_drain_empty", 32'(dac_valid), 0);
    dac_ready = 0;

    // Reset in the middle of an acked transaction.
    bus_addr = BASE + 4; bus_read = 1;
    for (int i = 0; i < 20 && !bus_ack; i++) @(negedge clk);
    check("midreset_ack_seen", 32'(bus_ack), 1);
    rst = 0;
    #1;
    check("midreset_ack_drop", 32'(bus_ack), 0);
    bus_read = 0;
    @(negedge clk);
    rst = 1;
    model_reset();
    @(negedge clk);
    bus_rd(BASE + 4, rdata);
    check("post_reset_space", rdata, 32'h0404_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
